// File: rtl/control_unit.sv
// Multicycle control FSM for the K&S processor: fetch, decode and execute
// sequencing with a configurable RAM read latency.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_HALT   = 4'd13
  } decoded_instruction_type;
endpackage

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED
  } state_t;

  localparam logic [1:0] LAST = 2'(RAM_LATENCY - 1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       last;
  logic       taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last = (cnt_q == LAST);

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      decoded_instruction == I_BZERO:  taken = zero_op;
      decoded_instruction == I_BNZERO: taken = !zero_op;
      decoded_instruction == I_BNEG:   taken = neg_op;
      decoded_instruction == I_BNNEG:  taken = !neg_op;
      default:                         taken = 1'b0;
    endcase
  end

  // Outputs are gated by rst_n so reset clears them without a clock edge.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_FETCH: begin
          if (last) begin
            ir_enable = 1'b1;
            pc_enable = 1'b1;
            state_d   = S_DECODE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        S_DECODE: state_d = S_EXEC;
        S_EXEC: begin
          state_d = S_FETCH;
          cnt_d   = '0;
          case (decoded_instruction)
            I_LOAD: begin
              addr_sel = 1'b1;
              c_sel    = 1'b1;
              if (last) begin
                write_reg_enable = 1'b1;
              end else begin
                state_d = S_EXEC;
                cnt_d   = cnt_q + 2'd1;
              end
            end
            I_STORE: begin
              addr_sel         = 1'b1;
              ram_write_enable = 1'b1;
            end
            I_MOVE: begin
              operation        = 2'b11;
              write_reg_enable = 1'b1;
            end
            I_ADD, I_SUB, I_AND, I_OR: begin
              operation        = decoded_instruction[1:0];
              write_reg_enable = 1'b1;
              flags_reg_enable = 1'b1;
            end
            I_BRANCH: begin
              branch    = 1'b1;
              pc_enable = 1'b1;
            end
            I_BZERO, I_BNZERO, I_BNEG, I_BNNEG: begin
              branch    = taken;
              pc_enable = taken;
            end
            I_HALT:  state_d = S_HALTED;
            default: state_d = S_FETCH;
          endcase
        end
        S_HALTED: halt = 1'b1;
        default:  state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed scoreboard bench for control_unit at RAM_LATENCY 1 and 3.
module tb_control_unit;
  import k_and_s_pkg::*;

  typedef logic [10:0] vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n = 1'b0;
  logic rst3_n = 1'b0;
  decoded_instruction_type instr = I_NOP;
  logic zero_op = 1'b0;
  logic neg_op = 1'b0;

  logic br1, pc1, ir1, as1, cs1, wr1, fr1, rw1, h1;
  logic br3, pc3, ir3, as3, cs3, wr3, fr3, rw3, h3;
  logic [1:0] op1, op3;

  control_unit #(.RAM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .decoded_instruction(instr),
    .zero_op(zero_op), .neg_op(neg_op),
    .branch(br1), .pc_enable(pc1), .ir_enable(ir1),
    .addr_sel(as1), .c_sel(cs1), .operation(op1),
    .write_reg_enable(wr1), .flags_reg_enable(fr1),
    .ram_write_enable(rw1), .halt(h1)
  );

  control_unit #(.RAM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .decoded_instruction(instr),
    .zero_op(zero_op), .neg_op(neg_op),
    .branch(br3), .pc_enable(pc3), .ir_enable(ir3),
    .addr_sel(as3), .c_sel(cs3), .operation(op3),
    .write_reg_enable(wr3), .flags_reg_enable(fr3),
    .ram_write_enable(rw3), .halt(h3)
  );

  int   sel = 0;
  vec_t obs;
  assign obs = (sel != 0)
    ? {br3, pc3, ir3, as3, cs3, op3, wr3, fr3, rw3, h3}
    : {br1, pc1, ir1, as1, cs1, op1, wr1, fr1, rw1, h1};

  vec_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic wmon = 1'b0;
  int   wre_seen = 0;

  always @(negedge clk)
    if (wmon && wr3) wre_seen++;

  function automatic vec_t mk(input logic br, pc, ir, as, cs,
                              input logic [1:0] op,
                              input logic wre, fre, rwe, h);
    return {br, pc, ir, as, cs, op, wre, fre, rwe, h};
  endfunction

  task automatic check(input string tag, input vec_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_fetch_decode();
    int lat;
    lat = (sel != 0) ? 3 : 1;
    for (int i = 0; i < lat; i++)
      q.push_back((i == lat - 1) ? mk(0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0) : '0);
    q.push_back('0);
  endtask

  task automatic push_exec(input decoded_instruction_type i,
                           input logic z, input logic n);
    int   lat;
    logic tk;
    lat = (sel != 0) ? 3 : 1;
    tk  = 1'b0;
    case (i)
      I_LOAD:
        for (int k = 0; k < lat; k++)
          q.push_back(mk(0, 0, 0, 1, 1, 2'b00, k == lat - 1, 0, 0, 0));
      I_STORE:  q.push_back(mk(0, 0, 0, 1, 0, 2'b00, 0, 0, 1, 0));
      I_MOVE:   q.push_back(mk(0, 0, 0, 0, 0, 2'b11, 1, 0, 0, 0));
      I_ADD:    q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0));
      I_SUB:    q.push_back(mk(0, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0));
      I_AND:    q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 1, 1, 0, 0));
      I_OR:     q.push_back(mk(0, 0, 0, 0, 0, 2'b11, 1, 1, 0, 0));
      I_BRANCH: q.push_back(mk(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      I_BZERO, I_BNZERO, I_BNEG, I_BNNEG: begin
        if (i == I_BZERO)  tk = z;
        if (i == I_BNZERO) tk = !z;
        if (i == I_BNEG)   tk = n;
        if (i == I_BNNEG)  tk = !n;
        q.push_back(mk(tk, tk, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      end
      default:  q.push_back('0);
    endcase
  endtask

  task automatic drain(input string tag);
    vec_t exp;
    while (q.size() > 0) begin
      exp = q.pop_front();
      @(negedge clk);
      check(tag, exp);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input decoded_instruction_type i, input logic z,
                     input logic n, input string tag);
    instr   = i;
    zero_op = z;
    neg_op  = n;
    push_fetch_decode();
    push_exec(i, z, n);
    drain(tag);
  endtask

  task automatic start(input int s);
    rst1_n = 1'b0;
    rst3_n = 1'b0;
    sel    = s;
    instr  = I_NOP;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", '0);
    if (s != 0) rst3_n = 1'b1;
    else        rst1_n = 1'b1;
  endtask

  initial begin
    #2;
    check("reset_at_time0", '0);

    start(0);
    run(I_NOP, 0, 0, "nop_c0");
    run(I_NOP, 0, 0, "nop_c3");
    run(I_NOP, 0, 0, "nop_c6");
    run(I_ADD, 0, 0, "add");
    run(I_SUB, 0, 0, "sub");
    run(I_AND, 0, 0, "and");
    run(I_OR, 0, 0, "or");
    run(I_MOVE, 0, 0, "move");
    run(I_STORE, 0, 0, "store");
    run(I_LOAD, 0, 0, "load_l1");
    run(I_BRANCH, 0, 0, "branch");
    run(I_BZERO, 1, 0, "bzero_taken");
    run(I_BZERO, 0, 0, "bzero_not");
    run(I_BNZERO, 0, 0, "bnzero_taken");
    run(I_BNZERO, 1, 0, "bnzero_not");
    run(I_BNEG, 0, 1, "bneg_taken");
    run(I_BNEG, 0, 0, "bneg_not");
    run(I_BNNEG, 0, 0, "bnneg_taken");
    run(I_BNNEG, 0, 1, "bnneg_not");
    run(decoded_instruction_type'(4'hF), 1, 1, "illegal_nop");
    run(I_HALT, 0, 0, "halt_instr");
    instr = I_ADD;
    for (int k = 0; k < 20; k++) begin
      q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
    end
    drain("halted");
    rst1_n = 1'b0;
    #1;
    check("halt_async_reset", '0);

    start(1);
    run(I_LOAD, 0, 0, "load_l3");
    run(I_ADD, 0, 0, "add_l3");
    run(I_BZERO, 1, 0, "bzero_l3");

    wmon     = 1'b1;
    wre_seen = 0;
    instr    = I_LOAD;
    push_fetch_decode();
    q.push_back(mk(0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0));
    drain("abort_pre");
    rst3_n = 1'b0;
    #1;
    check("abort_async_reset", '0);
    repeat (3) @(posedge clk);
    #1;
    rst3_n = 1'b1;
    run(I_NOP, 0, 0, "refetch_after_abort");
    wmon = 1'b0;
    tests++;
    assert (wre_seen == 0) else begin
      fails++;
      $error("FAIL abort_no_write observed=%0d expected=0", wre_seen);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
